// File: rtl/chunk_adder.sv
// chunk_adder: multi-cycle adder/subtractor that adds CHUNK bits per clock, LSB slice first
module chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             sub_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;
  logic [CHUNK:0]   w_add;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_last;
  logic             w_accept;
  logic             w_msb_cin;

  assign w_accept  = start_i && (r_state != S_BUSY);
  assign w_last    = (r_state == S_BUSY) && (r_idx == IW'(NCHUNK - 1));
  assign w_add     = {1'b0, r_a[r_idx*CHUNK +: CHUNK]} + {1'b0, r_b[r_idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, r_carry};
  // Carry into the MSB is recovered from the MSB sum bit and its (already inverted) operands.
  assign w_msb_cin = r_a[WIDTH-1] ^ r_b[WIDTH-1] ^ w_add[CHUNK-1];

  // Merge the current slice result into the accumulator image.
  always_comb begin
    w_acc_next = r_acc;
    w_acc_next[r_idx*CHUNK +: CHUNK] = w_add[CHUNK-1:0];
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; a start in DONE is accepted back-to-back, a start in BUSY is ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = start_i ? S_BUSY : S_IDLE;
      S_BUSY:  w_next = w_last ? S_DONE : S_BUSY;
      S_DONE:  w_next = start_i ? S_BUSY : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Status outputs decode directly from the state.
  always_comb begin
    busy_o = (r_state == S_BUSY);
    done_o = (r_state == S_DONE);
  end

  // Datapath: operand capture on accept, one slice per BUSY cycle, result commit on the last slice.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= src1_i;
      r_b     <= src2_i ^ {WIDTH{sub_i}};
      r_carry <= sub_i;
      r_idx   <= '0;
    end else if (r_state == S_BUSY) begin
      r_acc   <= w_acc_next;
      r_carry <= w_add[CHUNK];
      r_idx   <= r_idx + 1'b1;
      if (w_last) begin
        r_sum  <= w_acc_next;
        r_cout <= w_add[CHUNK];
        r_ovf  <= w_msb_cin ^ w_add[CHUNK];
      end
    end
  end

  assign sum_o  = r_sum;
  assign cout_o = r_cout;
  assign ovf_o  = r_ovf;
  assign zero_o = ~|r_sum;
endmodule

// File: doc/chunk_adder.md
CHUNK_ADDER -- requirements
Module: chunk_adder

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits.
REQ-002 Parameter CHUNK, default 4, bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, NCHUNK = WIDTH/CHUNK.
REQ-003 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  request a new operation; sampled on the rising edge.
REQ-006 sub_i  input  1  0 = add, 1 = subtract (src1_i - src2_i); sampled with start_i.
REQ-007 src1_i  input  WIDTH  first operand, sampled with start_i.
REQ-008 src2_i  input  WIDTH  second operand, sampled with start_i.
REQ-009 busy_o  output  1  high while an operation is in progress.
REQ-010 done_o  output  1  one-cycle pulse marking a new valid result.
REQ-011 sum_o  output  WIDTH  result register.
REQ-012 cout_o  output  1  carry out of the MSB (subtract: 1 = no borrow).
REQ-013 ovf_o  output  1  two's-complement signed overflow.
REQ-014 zero_o  output  1  high when sum_o is all zeros.

Function
REQ-015 FSM states are IDLE, BUSY and DONE.
REQ-016 IDLE or DONE with start_i = 1: latch src1_i, src2_i XOR {WIDTH{sub_i}}, carry = sub_i, chunk index = 0; go to BUSY.
REQ-017 IDLE with start_i = 0: stay in IDLE. DONE with start_i = 0: go to IDLE.
REQ-018 BUSY: each cycle adds one CHUNK-bit slice, LSB slice first, into an internal accumulator; carry is propagated to the next slice; index increments.
REQ-019 BUSY with index = NCHUNK-1: the final slice is added; sum_o, cout_o, ovf_o and zero_o update on the same edge; go to DONE.
REQ-020 Latency: with start_i sampled at edge k, results and done_o = 1 appear after edge k+NCHUNK (8 cycles at the defaults).
REQ-021 busy_o = 1 exactly in BUSY; done_o = 1 exactly in DONE.
REQ-022 start_i in BUSY is ignored: operands and sub_i are not re-sampled and the operation in progress is not disturbed.
REQ-023 start_i in DONE is accepted (back-to-back); done_o still pulses for that cycle.
REQ-024 sum_o, cout_o, ovf_o and zero_o hold their last values in IDLE, BUSY and DONE until the next completion; partial sums never appear on sum_o.
REQ-025 Arithmetic is modulo 2^WIDTH; ovf_o = carry into the MSB XOR carry out of the MSB.
REQ-026 zero_o is derived from the registered sum_o value.
REQ-027 CHUNK = WIDTH SHALL be legal (single BUSY cycle); CHUNK = 1 SHALL be legal (bit-serial).

Reset
REQ-028 rst_i = 0 at any time, including mid-BUSY, asynchronously forces IDLE with busy_o = 0, done_o = 0, sum_o = 0, cout_o = 0, ovf_o = 0, zero_o = 1, and clears the index, carry and operand registers.
REQ-029 An operation aborted by reset SHALL NOT produce done_o after reset is released; a new start_i is required.

Verification
REQ-030 Add 0x0000_0001 + 0xFFFF_FFFF, defaults -> after 8 cycles: done_o pulse, sum_o = 0, cout_o = 1, ovf_o = 0, zero_o = 1.
REQ-031 Add 0x7FFF_FFFF + 0x0000_0001 -> sum_o = 0x8000_0000, cout_o = 0, ovf_o = 1, zero_o = 0; busy_o high for exactly 8 cycles.
REQ-032 Subtract 5 - 7 -> sum_o = 0xFFFF_FFFE, cout_o = 0, ovf_o = 0. Subtract 0x8000_0000 - 1 -> sum_o = 0x7FFF_FFFF, cout_o = 1, ovf_o = 1.
REQ-033 Pulse start_i again in cycle 3 of BUSY with different operands -> first result unchanged and delivered at cycle 8; second request ignored.
REQ-034 Back-to-back: start_i held high in the DONE cycle -> second result arrives 8 cycles later; done_o pulses once per operation.
REQ-035 Drive rst_i low in cycle 4 of BUSY -> all outputs immediately take reset values; no done_o after release. Repeat REQ-030 with CHUNK = 1 (32-cycle latency) and CHUNK = 32 (1-cycle latency).
